// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, hazard flag bundle and register-match helper for the
// ID-stage hazard controller.
package hazard_ctrl_pkg;

    localparam int          MDU_LATENCY_DEF = 32;
    localparam int          STALL_CNT_W     = 32;
    localparam int          MDU_CNT_W       = 6;
    localparam logic [4:0]  REG_ZERO        = 5'd0;

    typedef struct packed {
        logic load_use;
        logic br_haz;
        logic mdu_haz;
    } hazard_t;

    // A producer matches a consumer when it writes a nonzero register the
    // consumer reads; rt only counts when the instruction actually reads it.
    function automatic logic reg_match(
        input logic       wr,
        input logic [4:0] rd,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return wr && (rd != REG_ZERO) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_mdu.sv
// Multiply/divide busy window: a down-counter reloaded on every start.
module mdu_busy_tracker
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = MDU_LATENCY_DEF
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Start,
    output logic Busy
);

    localparam logic [MDU_CNT_W-1:0] LAT = MDU_CNT_W'(MDU_LATENCY);

    logic [MDU_CNT_W-1:0] cnt;

    // Start wins over decrement, so a restart at count 1 leaves no idle gap.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            cnt <= '0;
        else if (Start)
            cnt <= LAT;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign Busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use / branch-operand / MDU stalls, jump and
// flush gating, and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = MDU_LATENCY_DEF,
    parameter int CNT_W       = STALL_CNT_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             ID_Valid,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_Branch,
    input  logic             ID_Jump,
    input  logic             ID_MduUse,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rd,
    input  logic             EX_MduStart,
    input  logic             MEM_MemRead,
    input  logic [4:0]       MEM_Rd,
    input  logic             Branch_Taken,
    output logic             PC_Sub_4_Data,
    output logic             IF_ID_Hold,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             Jump,
    output logic             Mdu_Busy,
    output logic [CNT_W-1:0] Stall_Count
);

    logic    match_ex;
    logic    match_mem;
    hazard_t haz;
    logic    stall;

    mdu_busy_tracker #(.MDU_LATENCY(MDU_LATENCY)) u_mdu (
        .Clock (Clock),
        .Reset (Reset),
        .Start (EX_MduStart),
        .Busy  (Mdu_Busy)
    );

    assign match_ex  = reg_match(EX_RegWrite, EX_Rd,  ID_Rs, ID_Rt, ID_UsesRt);
    assign match_mem = reg_match(MEM_MemRead, MEM_Rd, ID_Rs, ID_Rt, ID_UsesRt);

    always_comb begin
        haz          = '0;
        haz.load_use = EX_MemRead && match_ex;
        haz.br_haz   = ID_Branch && (match_ex || match_mem);
        haz.mdu_haz  = ID_MduUse && Mdu_Busy;
    end

    // Reset forces every combinational output low regardless of inputs.
    assign stall = !Reset && ID_Valid && (|haz);

    assign PC_Sub_4_Data = stall;
    assign IF_ID_Hold    = stall;
    assign ID_EX_Bubble  = stall;

    // A stalled control instruction redirects on its first unstalled cycle.
    assign Jump        = !Reset && !stall && ID_Valid && ID_Jump;
    assign IF_ID_Flush = !Reset && !stall &&
                         ((ID_Valid && ID_Jump) || (ID_Branch && Branch_Taken));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            Stall_Count <= '0;
        else if (stall && (Stall_Count != {CNT_W{1'b1}}))
            Stall_Count <= Stall_Count + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table plus multi-cycle
// sequences for stalls, MDU window, async reset and counter saturation.
module tb_hazard_ctrl;

    localparam int LAT = 4;
    localparam int CW  = 4;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          ID_Valid, ID_UsesRt, ID_Branch, ID_Jump, ID_MduUse;
    logic [4:0]    ID_Rs, ID_Rt, EX_Rd, MEM_Rd;
    logic          EX_RegWrite, EX_MemRead, EX_MduStart, MEM_MemRead, Branch_Taken;
    logic          PC_Sub_4_Data, IF_ID_Hold, IF_ID_Flush, ID_EX_Bubble, Jump, Mdu_Busy;
    logic [CW-1:0] Stall_Count;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    hazard_ctrl #(.MDU_LATENCY(LAT), .CNT_W(CW)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .ID_Valid      (ID_Valid),
        .ID_Rs         (ID_Rs),
        .ID_Rt         (ID_Rt),
        .ID_UsesRt     (ID_UsesRt),
        .ID_Branch     (ID_Branch),
        .ID_Jump       (ID_Jump),
        .ID_MduUse     (ID_MduUse),
        .EX_RegWrite   (EX_RegWrite),
        .EX_MemRead    (EX_MemRead),
        .EX_Rd         (EX_Rd),
        .EX_MduStart   (EX_MduStart),
        .MEM_MemRead   (MEM_MemRead),
        .MEM_Rd        (MEM_Rd),
        .Branch_Taken  (Branch_Taken),
        .PC_Sub_4_Data (PC_Sub_4_Data),
        .IF_ID_Hold    (IF_ID_Hold),
        .IF_ID_Flush   (IF_ID_Flush),
        .ID_EX_Bubble  (ID_EX_Bubble),
        .Jump          (Jump),
        .Mdu_Busy      (Mdu_Busy),
        .Stall_Count   (Stall_Count)
    );

    typedef struct {
        string      name;
        logic       v;
        logic [4:0] rs, rt;
        logic       ur, br, j;
        logic       exw, exm;
        logic [4:0] exrd;
        logic       memm;
        logic [4:0] memrd;
        logic       bt;
        logic       e_stall, e_flush, e_jump;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clr();
        ID_Valid = 0; ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0; ID_Branch = 0; ID_Jump = 0;
        ID_MduUse = 0; EX_RegWrite = 0; EX_MemRead = 0; EX_Rd = 0; EX_MduStart = 0;
        MEM_MemRead = 0; MEM_Rd = 0; Branch_Taken = 0;
    endtask

    task automatic do_reset();
        clr();
        Reset = 1;
        tick();
        Reset = 0;
        #1;
    endtask

    task automatic load_use8();
        ID_Valid = 1; ID_Rs = 8; EX_RegWrite = 1; EX_MemRead = 1; EX_Rd = 8;
    endtask

    function automatic logic [4:0] outs();
        return {PC_Sub_4_Data, IF_ID_Hold, ID_EX_Bubble, IF_ID_Flush, Jump};
    endfunction

    initial begin
        //            name         v rs rt ur br j exw exm exrd memm memrd bt  st fl jp
        tbl[0]  = '{"lu_rs",       1, 8, 0, 0, 0, 0, 1, 1, 8,  0, 0,  0, 1, 0, 0};
        tbl[1]  = '{"reg_zero",    1, 0, 0, 1, 0, 0, 1, 1, 0,  0, 0,  0, 0, 0, 0};
        tbl[2]  = '{"rt_unused",   1, 1, 8, 0, 0, 0, 1, 1, 8,  0, 0,  0, 0, 0, 0};
        tbl[3]  = '{"lu_rt",       1, 1, 8, 1, 0, 0, 1, 1, 8,  0, 0,  0, 1, 0, 0};
        tbl[4]  = '{"id_invalid",  0, 8, 0, 0, 0, 0, 1, 1, 8,  0, 0,  0, 0, 0, 0};
        tbl[5]  = '{"ex_alu_fwd",  1, 8, 0, 0, 0, 0, 1, 0, 8,  0, 0,  0, 0, 0, 0};
        tbl[6]  = '{"br_ex_alu",   1, 8, 9, 1, 1, 0, 1, 0, 9,  0, 0,  0, 1, 0, 0};
        tbl[7]  = '{"br_mem_ld",   1, 8, 9, 1, 1, 0, 0, 0, 0,  1, 8,  0, 1, 0, 0};
        tbl[8]  = '{"mem_ld_nobr", 1, 8, 9, 1, 0, 0, 0, 0, 0,  1, 8,  0, 0, 0, 0};
        tbl[9]  = '{"br_taken",    1, 8, 9, 1, 1, 0, 0, 0, 0,  0, 0,  1, 0, 1, 0};
        tbl[10] = '{"jump",        1, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0,  0, 0, 1, 1};
        tbl[11] = '{"jump_lu",     1, 8, 0, 0, 0, 1, 1, 1, 8,  0, 0,  0, 1, 0, 0};
        tbl[12] = '{"br_tk_haz",   1, 8, 9, 1, 1, 0, 1, 1, 9,  0, 0,  1, 1, 0, 0};
        tbl[13] = '{"bt_nobranch", 1, 8, 9, 1, 0, 0, 0, 0, 0,  0, 0,  1, 0, 0, 0};
        tbl[14] = '{"jump_invld",  0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0,  0, 0, 0, 0};
        tbl[15] = '{"br_mem_rt0",  1, 8, 0, 1, 1, 0, 0, 0, 0,  1, 0,  0, 0, 0, 0};

        // Reset state, with a load-use pattern driven during reset.
        clr();
        load_use8();
        ID_Jump = 1;
        #2;
        chk("reset_outs",  32'(outs()), 32'd0);
        chk("reset_busy",  32'(Mdu_Busy), 32'd0);
        chk("reset_count", 32'(Stall_Count), 32'd0);
        do_reset();

        foreach (tbl[i]) begin
            clr();
            ID_Valid = tbl[i].v; ID_Rs = tbl[i].rs; ID_Rt = tbl[i].rt; ID_UsesRt = tbl[i].ur;
            ID_Branch = tbl[i].br; ID_Jump = tbl[i].j; EX_RegWrite = tbl[i].exw;
            EX_MemRead = tbl[i].exm; EX_Rd = tbl[i].exrd; MEM_MemRead = tbl[i].memm;
            MEM_Rd = tbl[i].memrd; Branch_Taken = tbl[i].bt;
            #1;
            chk(tbl[i].name, 32'(outs()),
                32'({tbl[i].e_stall, tbl[i].e_stall, tbl[i].e_stall, tbl[i].e_flush, tbl[i].e_jump}));
            tick();
        end

        // Load-use: one stall cycle, counter 0 -> 1.
        do_reset();
        load_use8();
        #1;
        chk("lu_stall_c1", 32'(outs()), 32'b11100);
        chk("lu_cnt_c1",   32'(Stall_Count), 32'd0);
        tick();
        EX_RegWrite = 0; EX_MemRead = 0; EX_Rd = 0; MEM_MemRead = 1; MEM_Rd = 8;
        #1;
        chk("lu_stall_c2", 32'(outs()), 32'b00000);
        chk("lu_cnt_c2",   32'(Stall_Count), 32'd1);
        tick();
        chk("lu_cnt_c3",   32'(Stall_Count), 32'd1);

        // Branch behind load: stall in EX, then in MEM, then redirect.
        do_reset();
        ID_Valid = 1; ID_Rs = 5; ID_Rt = 6; ID_UsesRt = 1; ID_Branch = 1;
        EX_RegWrite = 1; EX_MemRead = 1; EX_Rd = 5;
        #1;
        chk("br_ld_c1", 32'(outs()), 32'b11100);
        tick();
        EX_RegWrite = 0; EX_MemRead = 0; EX_Rd = 0; MEM_MemRead = 1; MEM_Rd = 5;
        #1;
        chk("br_ld_c2", 32'(outs()), 32'b11100);
        tick();
        MEM_MemRead = 0; MEM_Rd = 0; Branch_Taken = 1;
        #1;
        chk("br_ld_c3",  32'(outs()), 32'b00010);
        chk("br_ld_cnt", 32'(Stall_Count), 32'd2);
        tick();
        clr();
        ID_Valid = 1; ID_Rs = 3;
        #1;
        chk("br_ld_c4",  32'(outs()), 32'b00000);
        chk("br_ld_cnt2", 32'(Stall_Count), 32'd2);

        // Jump held back by a load-use stall, then taken.
        do_reset();
        load_use8();
        ID_Jump = 1;
        #1;
        chk("jmp_gate_c1", 32'(outs()), 32'b11100);
        tick();
        EX_RegWrite = 0; EX_MemRead = 0; EX_Rd = 0; MEM_MemRead = 1; MEM_Rd = 8;
        #1;
        chk("jmp_gate_c2", 32'(outs()), 32'b00011);

        // MDU window: four busy/stall cycles after a start.
        do_reset();
        EX_MduStart = 1; ID_Valid = 1;
        #1;
        chk("mdu_pre_busy", 32'(Mdu_Busy), 32'd0);
        tick();
        EX_MduStart = 0; ID_MduUse = 1;
        for (int k = 0; k < LAT; k++) begin
            #1;
            chk($sformatf("mdu_busy_%0d", k), 32'({Mdu_Busy, PC_Sub_4_Data}), 32'b11);
            tick();
        end
        #1;
        chk("mdu_idle",  32'({Mdu_Busy, PC_Sub_4_Data}), 32'b00);
        chk("mdu_cnt",   32'(Stall_Count), 32'd4);

        // Restart in the count==1 cycle extends the window by four more.
        ID_MduUse = 0; EX_MduStart = 1;
        tick();
        EX_MduStart = 0;
        tick(); tick(); tick();
        EX_MduStart = 1;
        #1;
        chk("mdu_rs_at1", 32'(Mdu_Busy), 32'd1);
        tick();
        EX_MduStart = 0;
        for (int k = 0; k < LAT; k++) begin
            #1;
            chk($sformatf("mdu_ext_%0d", k), 32'(Mdu_Busy), 32'd1);
            tick();
        end
        #1;
        chk("mdu_ext_end", 32'(Mdu_Busy), 32'd0);

        // Asynchronous reset mid-busy with a stall active.
        do_reset();
        EX_MduStart = 1;
        tick();
        EX_MduStart = 0; ID_Valid = 1; ID_MduUse = 1;
        tick();
        #1;
        chk("ar_pre_stall", 32'({Mdu_Busy, PC_Sub_4_Data}), 32'b11);
        Reset = 1;
        #1;
        chk("ar_outs",  32'(outs()), 32'd0);
        chk("ar_busy",  32'(Mdu_Busy), 32'd0);
        chk("ar_count", 32'(Stall_Count), 32'd0);
        Reset = 0;
        #1;
        chk("ar_after", 32'({Mdu_Busy, PC_Sub_4_Data}), 32'b00);

        // Saturation of the 4-bit counter.
        do_reset();
        load_use8();
        for (int k = 0; k < 15; k++) tick();
        chk("sat_15", 32'(Stall_Count), 32'd15);
        for (int k = 0; k < 5; k++) tick();
        chk("sat_20", 32'(Stall_Count), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control block that generates the hold, flush and jump controls consumed by the PC register and the IF/ID and ID/EX pipeline registers.
- Detects load-use and branch-operand hazards, tracks the multiply/divide unit (MDU) busy window, and gates jumps and flushes while the pipe is stalled.
- Keeps a saturating stall-cycle counter for performance measurement.
- Sits in the ID stage next to the register file and drives `PC_Sub_4_Data` and `Jump` into the PC register.

Parameters:
- MDU_LATENCY, 32, number of cycles the MDU stays busy after a start; legal range 1..63.
- CNT_W, 32, width of the stall performance counter.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ID_Valid  in  1  ID stage holds a real instruction.
- ID_Rs  in  5  ID source register rs.
- ID_Rt  in  5  ID source register rt.
- ID_UsesRt  in  1  ID instruction reads rt.
- ID_Branch  in  1  ID instruction is beq/bne, which compares operands in ID.
- ID_Jump  in  1  ID instruction is j/jal.
- ID_MduUse  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
- EX_RegWrite  in  1  EX instruction writes a GPR.
- EX_MemRead  in  1  EX instruction is a load.
- EX_Rd  in  5  EX destination register.
- EX_MduStart  in  1  EX instruction starts a mult/div this cycle.
- MEM_MemRead  in  1  MEM instruction is a load.
- MEM_Rd  in  5  MEM destination register.
- Branch_Taken  in  1  branch resolved taken in ID.
- PC_Sub_4_Data  out  1  hold the PC register (no update).
- IF_ID_Hold  out  1  hold the IF/ID register.
- IF_ID_Flush  out  1  zero the IF/ID register on the next edge.
- ID_EX_Bubble  out  1  insert a NOP into ID/EX.
- Jump  out  1  PC register loads the jump target.
- Mdu_Busy  out  1  MDU busy window is active.
- Stall_Count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - Clears the MDU counter to 0 and sets Stall_Count = 0.
  - While Reset = 1, every output is forced to 0 regardless of inputs.
- Hazard match definitions (register 0 never matches):
  - matchEX = EX_RegWrite && EX_Rd != 0 && (EX_Rd == ID_Rs || (ID_UsesRt && EX_Rd == ID_Rt)).
  - matchMEM = MEM_MemRead && MEM_Rd != 0 && (MEM_Rd == ID_Rs || (ID_UsesRt && MEM_Rd == ID_Rt)).
- Combinational stall; all terms are gated by ID_Valid:
  - loadUse = EX_MemRead && matchEX.
  - brHaz = ID_Branch && (matchEX || matchMEM). A branch behind a load therefore stalls 2 cycles: EX first, then MEM.
  - mduHaz = ID_MduUse && Mdu_Busy.
  - stall = loadUse || brHaz || mduHaz.
- Outputs on stall:
  - PC_Sub_4_Data = IF_ID_Hold = ID_EX_Bubble = stall, in the same cycle (zero latency).
- Jump and flush gating:
  - Jump = ID_Valid && ID_Jump && !stall.
  - IF_ID_Flush = !stall && ((ID_Valid && ID_Jump) || (ID_Branch && Branch_Taken)).
  - A stalled control instruction must not redirect; it redirects on the first unstalled cycle.
  - Hold and flush are never asserted together.
- MDU tracker:
  - 6-bit down-counter, with Mdu_Busy = (count != 0).
  - When EX_MduStart is sampled, the counter loads MDU_LATENCY.
  - Otherwise, while nonzero, it decrements by 1.
  - A start while already busy reloads MDU_LATENCY.
  - Start has priority over decrement.
  - A start arriving in the cycle the count reaches 1 reloads; no idle gap.
- Stall_Count:
  - +1 on each edge where stall = 1.
  - Saturates at all-ones with no wrap.
- Simultaneous events:
  - A load-use stall and an MDU stall in the same cycle count as one stall cycle.
  - Branch_Taken while stalled is ignored.
- Reset mid-MDU-busy clears Mdu_Busy immediately (asynchronous).

Decomposition:
- Add to the shared Para.v:
  - `MDU_LATENCY default
  - `REG_ZERO (5'd0)
  - `STALL_CNT_W
- Natural sub-module: mdu_busy_tracker, containing the counter, reload/decrement logic and Mdu_Busy output.
- Hazard compare, gating and the perf counter stay in hazard_ctrl.

Test Plan:
- Load-use stall:
  - Stimulus: lw $8 in EX (EX_MemRead = 1, EX_Rd = 8), ID add reads ID_Rs = 8.
  - Expected: PC_Sub_4_Data = IF_ID_Hold = ID_EX_Bubble = 1 for exactly 1 cycle; Stall_Count 0 -> 1.
- Register-zero exclusion:
  - Stimulus: EX_Rd = 0, EX_MemRead = 1, ID_Rs = 0.
  - Expected: no stall; all outputs 0.
- Branch behind load:
  - Stimulus: lw $5 in EX, then beq $5,$6 in ID with ID_Branch = 1.
  - Expected: stall 2 consecutive cycles, then Branch_Taken = 1 gives IF_ID_Flush = 1 for 1 cycle; Stall_Count = 2.
- Jump gated by stall:
  - Stimulus: ID_Jump = 1 together with loadUse.
  - Expected: Jump = 0 and IF_ID_Flush = 0 during the stall; Jump = 1 and IF_ID_Flush = 1 in the following cycle.
- MDU window (MDU_LATENCY = 4):
  - Stimulus: pulse EX_MduStart, then hold ID_MduUse = 1.
  - Expected: Mdu_Busy = 1 for 4 cycles and stall = 1 for those 4; a restart at count 1 extends busy by 4 more.
- Asynchronous reset:
  - Stimulus: assert Reset mid-MDU-busy with a stall active.
  - Expected: all outputs 0 immediately, before the next Clock edge; Stall_Count = 0.
- Saturation:
  - Stimulus: CNT_W = 4, 20 stall cycles.
  - Expected: Stall_Count holds at 15.
